// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_encoder
// Description : Encodes MIPS instruction fields into 32-bit machine words and
//               streams them to program memory through a small FIFO with a
//               sequenced byte-address counter.
// Options     : BRANCH_ABS_TARGET_EN - BEQ/BNE take an absolute byte target
//               from in_target and encode the PC-relative word offset.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]    ONE_CNT   = (PTR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, next_state;
  logic [31:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             accept, push, pop, legal, start_take, fifo_full;
  logic [31:0]      enc_word;
  logic [15:0]      branch_imm;

  assign fifo_full  = (count == FULL_CNT);
  assign in_ready   = (state == S_RUN) && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && legal;
  assign mem_we     = (count != '0) && ((state == S_RUN) || (state == S_DRAIN));
  assign pop        = mem_we && mem_ready;
  assign start_take = start && ((state == S_IDLE) || (state == S_DONE));
  assign done       = (state == S_DONE);
  assign mem_wdata  = (count != '0) ? fifo_mem[rd_ptr] : 32'd0;

`ifdef BRANCH_ABS_TARGET_EN
  logic [ADDR_W-1:0]        enq_addr;
  logic [ADDR_W-1:0]        br_diff;
  logic signed [ADDR_W+15:0] br_wide;

  // Branch offset relative to the branch's own PC+4, in words
  always_comb begin
    br_diff    = in_target[ADDR_W-1:0] - (enq_addr + ADDR_STEP);
    br_wide    = $signed({{16{br_diff[ADDR_W-1]}}, br_diff}) >>> 2;
    branch_imm = br_wide[15:0];
  end

  // Address the next enqueued word will be written to
  always_ff @(posedge clk) begin
    if (!reset)          enq_addr <= BASE_ADDR;
    else if (start_take) enq_addr <= BASE_ADDR;
    else if (push)       enq_addr <= enq_addr + ADDR_STEP;
  end
`else
  assign branch_imm = in_imm;
`endif

  // Field-to-word encoding; illegal classes flag legal=0
  always_comb begin
    legal    = 1'b1;
    enc_word = 32'd0;
    case (in_class)
      4'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
      4'd1:    enc_word = {6'h08, in_rs, in_rt, in_imm};
      4'd2:    enc_word = {6'h0d, in_rs, in_rt, in_imm};
      4'd3:    enc_word = {6'h0f, 5'd0, in_rt, in_imm};
      4'd4:    enc_word = {6'h23, in_rs, in_rt, in_imm};
      4'd5:    enc_word = {6'h2b, in_rs, in_rt, in_imm};
      4'd6:    enc_word = {6'h04, in_rs, in_rt, branch_imm};
      4'd7:    enc_word = {6'h05, in_rs, in_rt, branch_imm};
      4'd8:    enc_word = {6'h02, in_target};
      4'd9:    enc_word = {6'h03, in_target};
      default: legal    = 1'b0;
    endcase
  end

  // FIFO storage; contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  // FIFO pointers, occupancy, write address and sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem_addr <= BASE_ADDR;
      err      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        mem_addr <= mem_addr + ADDR_STEP;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (start_take) begin
        mem_addr <= BASE_ADDR;
        err      <= 1'b0;
      end else if (accept && !legal) begin
        err <= 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; DRAIN ends as soon as the final pop is taken
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (finish) next_state = S_DRAIN;
      S_DRAIN: if ((count == '0) || ((count == ONE_CNT) && pop)) next_state = S_DONE;
      S_DONE:  if (start) next_state = S_RUN;
      default: next_state = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_encoder
// Description : Directed self-checking bench for instruction_encoder. A second
//               instance with a 4-bit address space shares all inputs and is
//               used to observe address wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset, start, finish, in_valid, mem_ready;
  logic [3:0]  in_class;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, mem_we, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        w_in_ready, w_mem_we, w_done, w_err;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc;
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [31:0] wlog_addr [$];
  logic [31:0] beq_exp;

  instruction_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .done(done), .err(err)
  );

  instruction_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'hC)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_class(in_class),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .mem_we(w_mem_we), .mem_ready(mem_ready), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .done(w_done), .err(w_err)
  );

  always #5 clk = ~clk;

  // Record every completed memory write of both instances
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      log_addr.push_back(32'(mem_addr));
      log_data.push_back(mem_wdata);
    end
    if (w_mem_we && mem_ready) wlog_addr.push_back(32'(w_mem_addr));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    wlog_addr.delete();
  endtask

  task automatic set_fields(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [5:0] funct,
                            input logic [15:0] imm, input logic [25:0] tgt);
    in_class  = cls;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = 5'd0;
    in_funct  = funct;
    in_imm    = imm;
    in_target = tgt;
  endtask

  task automatic push_word(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [5:0] funct,
                           input logic [15:0] imm, input logic [25:0] tgt);
    set_fields(cls, rs, rt, rd, funct, imm, tgt);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic finish_wait();
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) break;
      cyc();
    end
    check("done_after_drain", 32'(done), 32'd1);
  endtask

  // Directed stimulus sequence
  initial begin
`ifdef BRANCH_ABS_TARGET_EN
    beq_exp = 32'h1109FFFD;
`else
    beq_exp = 32'h11090004;
`endif
    reset = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    cyc();
    cyc();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h00);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wrap_addr", 32'(w_mem_addr), 32'hC);
    reset = 1'b1;
    cyc();

    // Single ADDI
    do_start();
    check("run_in_ready", 32'(in_ready), 32'd1);
    push_word(4'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005, 26'd0);
    check("addi_we", 32'(mem_we), 32'd1);
    check("addi_addr", 32'(mem_addr), 32'h00);
    check("addi_data", mem_wdata, 32'h20080005);
    finish_wait();
    check("addi_count", 32'(log_addr.size()), 32'd1);

    // Back-to-back R, LUI, J
    clear_logs();
    do_start();
    check("restart_done", 32'(done), 32'd0);
    in_valid = 1'b1;
    set_fields(4'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0);
    cyc();
    check("r_addr", 32'(mem_addr), 32'h00);
    check("r_data", mem_wdata, 32'h01095020);
    set_fields(4'd3, 5'd0, 5'd1, 5'd0, 6'd0, 16'h1001, 26'd0);
    cyc();
    check("lui_we", 32'(mem_we), 32'd1);
    check("lui_addr", 32'(mem_addr), 32'h04);
    check("lui_data", mem_wdata, 32'h3C011001);
    set_fields(4'd8, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0100000);
    cyc();
    in_valid = 1'b0;
    check("j_addr", 32'(mem_addr), 32'h08);
    check("j_data", mem_wdata, 32'h08100000);
    finish_wait();
    check("b2b_count", 32'(log_addr.size()), 32'd3);

    // Branch as third word
    clear_logs();
    do_start();
    push_word(4'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0);
    push_word(4'd3, 5'd0, 5'd1, 5'd0, 6'd0, 16'h1001, 26'd0);
    push_word(4'd6, 5'd8, 5'd9, 5'd0, 6'd0, 16'h0004, 26'd0);
    check("beq_addr", 32'(mem_addr), 32'h08);
    check("beq_data", mem_wdata, beq_exp);
    finish_wait();

    // Stall with FIFO filling up
    clear_logs();
    do_start();
    mem_ready = 1'b0;
    n_acc = 0;
    set_fields(4'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd0, 26'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_imm = 16'(n_acc);
      if (in_ready) n_acc++;
      cyc();
      check("stall_addr", 32'(mem_addr), 32'h00);
      check("stall_data", mem_wdata, 32'h20080000);
    end
    in_valid = 1'b0;
    check("stall_accepts", 32'(n_acc), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_we", 32'(mem_we), 32'd1);
    mem_ready = 1'b1;
    #1;
    check("pop_at_full_ready", 32'(in_ready), 32'd0);
    cyc();
    check("after_pop_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) cyc();
    check("stall_count", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("stall_order_addr", log_addr[i], 32'(4 * i));
      check("stall_order_data", log_data[i], 32'h20080000 + 32'(i));
    end
    finish_wait();

    // Illegal class mid-stream
    clear_logs();
    do_start();
    check("err_cleared", 32'(err), 32'd0);
    push_word(4'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0001, 26'd0);
    push_word(4'd12, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0007, 26'd0);
    check("err_set", 32'(err), 32'd1);
    push_word(4'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0002, 26'd0);
    cyc();
    cyc();
    check("err_sticky", 32'(err), 32'd1);
    finish_wait();
    check("illegal_count", 32'(log_addr.size()), 32'd2);
    check("illegal_next_addr", log_addr[1], 32'h04);
    check("illegal_next_data", log_data[1], 32'h20080002);
    check("err_in_done", 32'(err), 32'd1);
    do_start();
    check("err_start_clear", 32'(err), 32'd0);

    // Address wrap on the 4-bit instance (already in RUN)
    clear_logs();
    in_valid = 1'b1;
    set_fields(4'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'h00FF, 26'd0);
    for (int i = 0; i < 5; i++) cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check("wrap_count", 32'(wlog_addr.size()), 32'd5);
    check("wrap_a0", wlog_addr[0], 32'hC);
    check("wrap_a1", wlog_addr[1], 32'h0);
    check("wrap_a2", wlog_addr[2], 32'h4);
    check("wrap_a4", wlog_addr[4], 32'hC);
    check("nowrap_a4", log_addr[4], 32'h10);
    check("ori_data", log_data[0], 32'h342200FF);
    finish_wait();

    // Reset during DRAIN with three words queued
    clear_logs();
    do_start();
    mem_ready = 1'b0;
    push_word(4'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0010, 26'd0);
    push_word(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0014, 26'd0);
    push_word(4'd9, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000040);
    check("lw_data", mem_wdata, 32'h8C220010);
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    check("drain_we", 32'(mem_we), 32'd1);
    check("drain_not_done", 32'(done), 32'd0);
    reset = 1'b0;
    cyc();
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'h00);
    check("abort_wrap_addr", 32'(w_mem_addr), 32'hC);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    mem_ready = 1'b1;
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    cyc();
    cyc();
    check("abort_no_writes", 32'(log_addr.size()), 32'd0);
    check("idle_ignores_finish", 32'(done), 32'd0);
    do_start();
    check("idle_to_run", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
